// File: rtl/bit_nto1_regmux_if.sv
// Channel-side and output-side signals of the NUM_IN:1 registered operand mux.
// The master drives the operand channels and out_ready; the slave is the mux itself.
interface bit_nto1_regmux_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = ($clog2(NUM_IN) < 1) ? 1 : $clog2(NUM_IN);

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/bit_nto1_regmux.sv
// NUM_IN:1 operand mux with one registered output stage; fixed or round-robin select.
// Optional REGMUX_XFER_CNT_EN adds a 16-bit wrapping count of accepted input transfers.
module bit_nto1_regmux #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef REGMUX_XFER_CNT_EN
  output logic [15:0]      xfer_cnt,
`endif
  bit_nto1_regmux_if.slave bus
);
  localparam int SEL_W = ($clog2(NUM_IN) < 1) ? 1 : $clog2(NUM_IN);
  localparam int SEL_N = 1 << SEL_W;

  // Handshake: a word moves on any edge where valid and ready are both high on the same
  // side. in_ready is one-hot or zero, never depends on in_data, and only rises when
  // the output stage is empty or being drained this cycle.

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_last_q, rr_last_d;

  logic [SEL_N-1:0]  valid_ext;
  logic              rr_hit;
  logic [SEL_W-1:0]  rr_idx;
  int                idx;
  logic              grant;
  logic [SEL_W-1:0]  gnt_idx;
  logic              ld;
  logic [NUM_IN-1:0] in_ready_c;
  logic [WIDTH-1:0]  chan_data;
  logic              xfer;

  always_comb begin
    // Zero-padded so an out-of-range sel lands on a 0 bit instead of X.
    valid_ext              = '0;
    valid_ext[NUM_IN-1:0]  = bus.in_valid;
    rr_hit                 = 1'b0;
    rr_idx                 = '0;
    idx                    = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = (int'(rr_last_q) + k) % NUM_IN;
      if (!rr_hit && valid_ext[SEL_W'(idx)]) begin
        rr_hit = 1'b1;
        rr_idx = SEL_W'(idx);
      end
    end

    grant   = bus.mode ? rr_hit : valid_ext[bus.sel];
    gnt_idx = bus.mode ? rr_idx : bus.sel;
    ld      = !out_valid_q || bus.out_ready;

    in_ready_c = '0;
    chan_data  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        chan_data = bus.in_data[i*WIDTH +: WIDTH];
        if (rst_n && ld && grant) in_ready_c[i] = 1'b1;
      end
    end
    xfer = |(bus.in_valid & in_ready_c);

    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_last_d   = rr_last_q;
    if (xfer) begin
      out_data_d  = chan_data;
      out_src_d   = gnt_idx;
      out_valid_d = 1'b1;
      if (bus.mode) rr_last_d = gnt_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      rr_last_q   <= SEL_W'(NUM_IN - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_last_q   <= rr_last_d;
    end
  end

`ifdef REGMUX_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (xfer) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt_q <= '0;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_bit_nto1_regmux.sv
// Directed bench for bit_nto1_regmux: a 4-channel instance for the main scenarios and
// a 3-channel instance for the out-of-range select and asynchronous reset cases.
module tb_bit_nto1_regmux;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bit_nto1_regmux_if #(.WIDTH(8), .NUM_IN(4)) bus4 ();
  bit_nto1_regmux_if #(.WIDTH(8), .NUM_IN(3)) bus3 ();

`ifdef REGMUX_XFER_CNT_EN
  logic [15:0] cnt4;
  logic [15:0] cnt3;
`endif

  bit_nto1_regmux #(.WIDTH(8), .NUM_IN(4)) u4 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef REGMUX_XFER_CNT_EN
    .xfer_cnt (cnt4),
`endif
    .bus      (bus4)
  );

  bit_nto1_regmux #(.WIDTH(8), .NUM_IN(3)) u3 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef REGMUX_XFER_CNT_EN
    .xfer_cnt (cnt3),
`endif
    .bus      (bus3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus4.mode      = 1'b0;
    bus4.sel       = 2'd0;
    bus4.in_data   = 32'h0;
    bus4.in_valid  = 4'hF;
    bus4.out_ready = 1'b1;
    bus3.mode      = 1'b0;
    bus3.sel       = 2'd0;
    bus3.in_data   = 24'h0;
    bus3.in_valid  = 3'b000;
    bus3.out_ready = 1'b1;
    #2;
    checks++;
    if (bus4.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %0b expected 0", bus4.out_valid);
    end
    checks++;
    if (bus4.out_data !== 8'h00) begin
      errors++; $display("FAIL reset_out_data: got %0h expected 00", bus4.out_data);
    end
    checks++;
    if (bus4.out_src !== 2'd0) begin
      errors++; $display("FAIL reset_out_src: got %0d expected 0", bus4.out_src);
    end
    checks++;
    if (bus4.in_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0000", bus4.in_ready);
    end
    bus4.in_valid = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    bus4.mode     = 1'b0;
    bus4.sel      = 2'd2;
    bus4.in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus4.in_valid = 4'b0100;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0100) begin
      errors++; $display("FAIL fixed_in_ready: got %b expected 0100", bus4.in_ready);
    end
    step();
    bus4.in_valid = 4'b0000;
    checks++;
    if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'hA5 || bus4.out_src !== 2'd2) begin
      errors++;
      $display("FAIL fixed_load: got v=%0b d=%0h s=%0d expected v=1 d=a5 s=2",
               bus4.out_valid, bus4.out_data, bus4.out_src);
    end
    step();
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'hA5 || bus4.out_src !== 2'd2) begin
      errors++;
      $display("FAIL fixed_drain: got v=%0b d=%0h s=%0d expected v=0 d=a5 s=2",
               bus4.out_valid, bus4.out_data, bus4.out_src);
    end
  endtask

  // The fixed-mode transfer above must not have moved the pointer: channel 0 goes first.
  task automatic test_rr_all();
    logic [1:0] exp_src;
    logic [3:0] exp_rdy;
    bus4.mode     = 1'b1;
    bus4.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus4.in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      exp_src = 2'(i % 4);
      exp_rdy = 4'b0001 << exp_src;
      #1;
      checks++;
      if (bus4.in_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_all_in_ready[%0d]: got %b expected %b", i, bus4.in_ready, exp_rdy);
      end
      step();
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_src !== exp_src || bus4.out_data !== (8'h10 + 8'(exp_src))) begin
        errors++;
        $display("FAIL rr_all_out[%0d]: got v=%0b s=%0d d=%0h expected v=1 s=%0d d=%0h",
                 i, bus4.out_valid, bus4.out_src, bus4.out_data, exp_src, 8'h10 + 8'(exp_src));
      end
    end
    bus4.in_valid = 4'h0;
    step();
  endtask

  task automatic test_rr_wrap();
    bus4.mode     = 1'b1;
    bus4.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus4.in_valid = 4'b1000;
    step();
    checks++;
    if (bus4.out_src !== 2'd3 || bus4.out_data !== 8'h13) begin
      errors++; $display("FAIL rr_wrap_seed: got s=%0d d=%0h expected s=3 d=13", bus4.out_src, bus4.out_data);
    end
    bus4.in_valid = 4'b1001;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0001) begin
      errors++; $display("FAIL rr_wrap_rdy0: got %b expected 0001", bus4.in_ready);
    end
    step();
    checks++;
    if (bus4.out_src !== 2'd0 || bus4.out_data !== 8'h10) begin
      errors++; $display("FAIL rr_wrap_g0: got s=%0d d=%0h expected s=0 d=10", bus4.out_src, bus4.out_data);
    end
    #1;
    checks++;
    if (bus4.in_ready !== 4'b1000) begin
      errors++; $display("FAIL rr_wrap_rdy3: got %b expected 1000", bus4.in_ready);
    end
    step();
    checks++;
    if (bus4.out_src !== 2'd3 || bus4.out_data !== 8'h13) begin
      errors++; $display("FAIL rr_wrap_g3: got s=%0d d=%0h expected s=3 d=13", bus4.out_src, bus4.out_data);
    end
    bus4.in_valid = 4'h0;
    step();
  endtask

  task automatic test_backpressure();
    bus4.mode      = 1'b0;
    bus4.sel       = 2'd1;
    bus4.in_data   = {8'h00, 8'h00, 8'h5A, 8'h00};
    bus4.in_valid  = 4'b0010;
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    bus4.in_data   = {8'h33, 8'h22, 8'h77, 8'h11};
    bus4.in_valid  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus4.in_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, bus4.in_ready);
      end
      step();
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'h5A || bus4.out_src !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%0b d=%0h s=%0d expected v=1 d=5a s=1",
                 i, bus4.out_valid, bus4.out_data, bus4.out_src);
      end
    end
    bus4.out_ready = 1'b1;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_release_rdy: got %b expected 0010", bus4.in_ready);
    end
    step();
    checks++;
    if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'h77 || bus4.out_src !== 2'd1) begin
      errors++;
      $display("FAIL bp_release_load: got v=%0b d=%0h s=%0d expected v=1 d=77 s=1",
               bus4.out_valid, bus4.out_data, bus4.out_src);
    end
    bus4.in_valid = 4'h0;
    step();
  endtask

  task automatic test_bad_sel();
    bus3.mode      = 1'b0;
    bus3.sel       = 2'd3;
    bus3.in_data   = {8'hC2, 8'hC1, 8'hC0};
    bus3.in_valid  = 3'b111;
    bus3.out_ready = 1'b1;
    #1;
    checks++;
    if (bus3.in_ready !== 3'b000) begin
      errors++; $display("FAIL bad_sel_in_ready: got %b expected 000", bus3.in_ready);
    end
    step();
    step();
    checks++;
    if (bus3.out_valid !== 1'b0) begin
      errors++; $display("FAIL bad_sel_out_valid: got %0b expected 0", bus3.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bus3.sel = 2'd0;
    step();
    bus3.in_valid = 3'b000;
    checks++;
    if (bus3.out_valid !== 1'b1 || bus3.out_data !== 8'hC0) begin
      errors++; $display("FAIL ares_load: got v=%0b d=%0h expected v=1 d=c0", bus3.out_valid, bus3.out_data);
    end
    bus3.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus3.out_valid !== 1'b0 || bus3.out_data !== 8'h00) begin
      errors++; $display("FAIL ares_async: got v=%0b d=%0h expected v=0 d=00", bus3.out_valid, bus3.out_data);
    end
    step();
    rst_n          = 1'b1;
    bus3.out_ready = 1'b1;
  endtask

`ifdef REGMUX_XFER_CNT_EN
  task automatic test_xfer_cnt();
    checks++;
    if (cnt4 !== 16'd0) begin
      errors++; $display("FAIL cnt_reset: got %0d expected 0", cnt4);
    end
    bus4.mode      = 1'b0;
    bus4.sel       = 2'd0;
    bus4.in_data   = {8'h04, 8'h03, 8'h02, 8'h01};
    bus4.in_valid  = 4'b0001;
    bus4.out_ready = 1'b1;
    repeat (5) step();
    bus4.in_valid = 4'b0000;
    repeat (2) step();
    checks++;
    if (cnt4 !== 16'd5) begin
      errors++; $display("FAIL cnt_five: got %0d expected 5", cnt4);
    end
    bus4.in_valid = 4'b0001;
    repeat (65530) step();
    checks++;
    if (cnt4 !== 16'hFFFF) begin
      errors++; $display("FAIL cnt_max: got %0h expected ffff", cnt4);
    end
    step();
    bus4.in_valid = 4'b0000;
    checks++;
    if (cnt4 !== 16'd0) begin
      errors++; $display("FAIL cnt_wrap: got %0h expected 0", cnt4);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_wrap();
    test_backpressure();
    test_bad_sel();
    test_async_reset();
`ifdef REGMUX_XFER_CNT_EN
    test_xfer_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_nto1_regmux.md
Name: bit_nto1_regmux

Overview:
- Parametrised successor to the team's fixed 8-bit 2:1 mux, for the ALU operand path.
- Selects one of NUM_IN channels of WIDTH bits and registers the result into a single output stage with a valid/ready handshake.
- Selection is either the direct `sel` index (fixed mode) or round-robin among the channels presenting valid data.
- Sits between operand sources (register file, immediate, forwarding) and the ALU input.

Parameters:
- WIDTH, 8: data bits per channel.
- NUM_IN, 4: number of input channels; legal range 2..16.
- SEL_W, derived localparam (not overridable): max(1, clog2(NUM_IN)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select via `sel`, 1 = round-robin.
- sel  input  SEL_W  channel index; used in fixed mode only.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel accept strobe; at most one bit high.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  index of the channel held in out_data.
- out_valid  output  1  output stage holds data.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer rr_last=NUM_IN-1, so channel 0 has first priority.
  - in_ready=0 while rst_n is low.
- Load enable: ld = !out_valid | out_ready. The stage can accept a new word in the same cycle the old one leaves (full throughput, no bubble).
- Fixed mode grant:
  - g = sel when in_valid[sel]=1 and sel<NUM_IN.
  - Otherwise no grant.
  - sel>=NUM_IN: never grants, no X propagation.
- Round-robin grant:
  - g = first i with in_valid[i]=1, searching rr_last+1, rr_last+2, … with modulo-NUM_IN wrap.
  - No valid input: no grant.
- in_ready[g] = ld & grant_exists. This is combinational from in_valid, mode, sel, out_valid, out_ready.
- Transfer on channel g: in_valid[g] & in_ready[g] at the clock edge. On that edge:
  - out_data <= channel g data.
  - out_src <= g.
  - out_valid <= 1.
  - In round-robin mode: rr_last <= g.
- rr_last updates only on round-robin transfers. Fixed-mode transfers leave it unchanged.
- Output drain: out_valid & out_ready with no new transfer gives out_valid <= 0. out_data and out_src keep their last value.
- Stall: while out_valid=1 and out_ready=0, out_data, out_src and out_valid are held stable and all in_ready=0.
- Latency: one cycle from accepted input to out_valid.
- Mode or sel change: affects only the next grant decision. A word already in the output stage is unaffected.
- Reset mid-transfer: the held word is discarded and out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: REGMUX_XFER_CNT_EN.
- Defined:
  - Adds output port xfer_cnt, 16 bits: count of accepted input transfers.
  - Reset value 0.
  - Increments by 1 per transfer and wraps 16'hFFFF -> 0.
  - Does not count output drains.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then fixed mode, sel=2, in_valid=4'b0100, channel 2 data=8'hA5, out_ready=1 -> in_ready=4'b0100. Next cycle: out_valid=1, out_data=8'hA5, out_src=2.
- Round-robin, all four in_valid held high, out_ready=1, channel data = 8'h10,8'h11,8'h12,8'h13 -> out_src sequence 0,1,2,3,0 on consecutive cycles; one word per cycle, no bubbles.
- Round-robin, in_valid=4'b1001, rr_last=3 after a channel-3 grant -> next grant is 0, then 3 (wrap-around order).
- Backpressure: out_valid=1 (8'h5A), out_ready=0 for 3 cycles while inputs are valid -> in_ready=0 and out_data=8'h5A stable throughout. Raise out_ready: the new word loads in the same cycle the held word drains.
- Fixed mode, NUM_IN=3, sel=3 -> in_ready=0 and out_valid stays 0. Then assert rst_n=0 with out_valid=1 -> out_valid=0 immediately, without waiting for clk.
- With REGMUX_XFER_CNT_EN defined: 5 transfers and 2 drain-only cycles -> xfer_cnt=5. Preload the count to 16'hFFFF and make one more transfer -> xfer_cnt=0.
